// File: rtl/cpu_load_store_align_if.sv
// Word-granular data cache bus between the load/store alignment stage (master) and the
// write-buffered data cache (slave).
interface cpu_load_store_align_if;
  logic        bus_request;
  logic        bus_rw;
  logic [31:0] bus_address;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_request,
    output bus_rw,
    output bus_address,
    output bus_wdata,
    input  bus_ready,
    input  bus_rdata
  );

  modport slave (
    input  bus_request,
    input  bus_rw,
    input  bus_address,
    input  bus_wdata,
    output bus_ready,
    output bus_rdata
  );
endinterface

// File: rtl/cpu_load_store_align.sv
// Load/store alignment stage: byte/half/word CPU accesses become aligned word transfers on a
// cache without byte enables. Define CPU_MEM_MISALIGNED_EN to split word-crossing accesses.
module cpu_load_store_align (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_request,
  input  logic                          i_rw,
  input  logic [1:0]                    i_width,
  input  logic                          i_signed,
  input  logic [31:0]                   i_address,
  input  logic [31:0]                   i_wdata,
  output logic                          o_ready,
  output logic [31:0]                   o_rdata,
  output logic                          o_error,
  cpu_load_store_align_if.master        bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StWr0,
    StAck
`ifdef CPU_MEM_MISALIGNED_EN
    ,
    StRd1,
    StWr1
`endif
  } state_e;

  state_e      state_q;
  logic        rw_q;
  logic        signed_q;
  logic [1:0]  width_q;
  logic [31:0] address_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q;
  logic        bus_request_q;
  logic        bus_rw_q;
  logic [31:0] bus_address_q;
  logic [31:0] bus_wdata_q;
`ifdef CPU_MEM_MISALIGNED_EN
  logic        cross_q;
  logic [31:0] hi_q;
`endif

  assign bus.bus_request = bus_request_q;
  assign bus.bus_rw      = bus_rw_q;
  assign bus.bus_address = bus_address_q;
  assign bus.bus_wdata   = bus_wdata_q;

  // Decode of the incoming command, used only in the capture cycle.
  logic req_fault;
  logic req_direct_store;
`ifdef CPU_MEM_MISALIGNED_EN
  logic [2:0] req_size;
  logic       req_cross;
  assign req_size  = (i_width == 2'b00) ? 3'd1 : (i_width == 2'b01) ? 3'd2 : 3'd4;
  assign req_cross = ({2'b00, i_address[1:0]} + {1'b0, req_size}) > 4'd4;
  assign req_fault = (i_width == 2'b11);
`else
  assign req_fault = (i_width == 2'b11) ||
                     ((i_width == 2'b01) && i_address[0]) ||
                     ((i_width == 2'b10) && (i_address[1:0] != 2'b00));
`endif
  assign req_direct_store = i_rw && (i_width == 2'b10) && (i_address[1:0] == 2'b00);

  logic [4:0]  shift;
  logic [31:0] base_address;
  logic [31:0] size_mask;
  logic [31:0] store_data;
  logic [31:0] merge_src;
  logic [31:0] merged_lo;
  logic [63:0] load_pair;
  logic [31:0] load_raw;
  logic [31:0] load_word;

  assign shift        = {address_q[1:0], 3'b000};
  assign base_address = {address_q[31:2], 2'b00};

  always_comb begin
    unique case (width_q)
      2'b00:   size_mask = 32'h0000_00ff;
      2'b01:   size_mask = 32'h0000_ffff;
      default: size_mask = 32'hffff_ffff;
    endcase
  end

  assign store_data = wdata_q & size_mask;
  // Low word comes straight off the bus in RD0, from lo_q once a second read has happened.
  assign merge_src  = (state_q == StRd0) ? bus.bus_rdata : lo_q;
  assign merged_lo  = (merge_src & ~(size_mask << shift)) | (store_data << shift);

`ifdef CPU_MEM_MISALIGNED_EN
  logic [5:0]  hi_shift;
  logic [31:0] merged_hi;
  assign hi_shift  = 6'd32 - {1'b0, shift};
  assign merged_hi = (hi_q & ~(size_mask >> hi_shift)) | (store_data >> hi_shift);
  assign load_pair = (state_q == StRd0) ? {32'h0, bus.bus_rdata} : {bus.bus_rdata, lo_q};
`else
  assign load_pair = {32'h0, bus.bus_rdata};
`endif

  assign load_raw = 32'(load_pair >> shift);

  always_comb begin
    unique case (width_q)
      2'b00:   load_word = {{24{signed_q & load_raw[7]}}, load_raw[7:0]};
      2'b01:   load_word = {{16{signed_q & load_raw[15]}}, load_raw[15:0]};
      default: load_word = load_raw;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= StIdle;
      rw_q          <= 1'b0;
      signed_q      <= 1'b0;
      width_q       <= 2'b00;
      address_q     <= 32'h0;
      wdata_q       <= 32'h0;
      lo_q          <= 32'h0;
      bus_request_q <= 1'b0;
      bus_rw_q      <= 1'b0;
      bus_address_q <= 32'h0;
      bus_wdata_q   <= 32'h0;
      o_ready       <= 1'b0;
      o_rdata       <= 32'h0;
      o_error       <= 1'b0;
`ifdef CPU_MEM_MISALIGNED_EN
      cross_q       <= 1'b0;
      hi_q          <= 32'h0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_request) begin
            rw_q      <= i_rw;
            signed_q  <= i_signed;
            width_q   <= i_width;
            address_q <= i_address;
            wdata_q   <= i_wdata;
            lo_q      <= 32'h0;
`ifdef CPU_MEM_MISALIGNED_EN
            cross_q   <= req_cross;
            hi_q      <= 32'h0;
`endif
            if (req_fault) begin
              state_q <= StAck;
              o_ready <= 1'b1;
              o_error <= 1'b1;
              o_rdata <= 32'h0;
            end else if (req_direct_store) begin
              state_q       <= StWr0;
              bus_request_q <= 1'b1;
              bus_rw_q      <= 1'b1;
              bus_address_q <= i_address;
              bus_wdata_q   <= i_wdata;
            end else begin
              state_q       <= StRd0;
              bus_request_q <= 1'b1;
              bus_rw_q      <= 1'b0;
              bus_address_q <= {i_address[31:2], 2'b00};
              bus_wdata_q   <= 32'h0;
            end
          end
        end

        StRd0: begin
          if (bus.bus_ready) begin
            lo_q <= bus.bus_rdata;
`ifdef CPU_MEM_MISALIGNED_EN
            if (cross_q) begin
              state_q       <= StRd1;
              bus_address_q <= base_address + 32'd4;
            end else
`endif
            if (!rw_q) begin
              state_q       <= StAck;
              bus_request_q <= 1'b0;
              bus_address_q <= 32'h0;
              o_ready       <= 1'b1;
              o_rdata       <= load_word;
            end else begin
              state_q     <= StWr0;
              bus_rw_q    <= 1'b1;
              bus_wdata_q <= merged_lo;
            end
          end
        end

`ifdef CPU_MEM_MISALIGNED_EN
        StRd1: begin
          if (bus.bus_ready) begin
            hi_q <= bus.bus_rdata;
            if (!rw_q) begin
              state_q       <= StAck;
              bus_request_q <= 1'b0;
              bus_address_q <= 32'h0;
              o_ready       <= 1'b1;
              o_rdata       <= load_word;
            end else begin
              state_q       <= StWr0;
              bus_rw_q      <= 1'b1;
              bus_address_q <= base_address;
              bus_wdata_q   <= merged_lo;
            end
          end
        end

        StWr1: begin
          if (bus.bus_ready) begin
            state_q       <= StAck;
            bus_request_q <= 1'b0;
            bus_rw_q      <= 1'b0;
            bus_address_q <= 32'h0;
            bus_wdata_q   <= 32'h0;
            o_ready       <= 1'b1;
            o_rdata       <= 32'h0;
          end
        end
`endif

        StWr0: begin
          if (bus.bus_ready) begin
`ifdef CPU_MEM_MISALIGNED_EN
            if (cross_q) begin
              state_q       <= StWr1;
              bus_address_q <= base_address + 32'd4;
              bus_wdata_q   <= merged_hi;
            end else
`endif
            begin
              state_q       <= StAck;
              bus_request_q <= 1'b0;
              bus_rw_q      <= 1'b0;
              bus_address_q <= 32'h0;
              bus_wdata_q   <= 32'h0;
              o_ready       <= 1'b1;
              o_rdata       <= 32'h0;
            end
          end
        end

        StAck: begin
          state_q <= StIdle;
          o_ready <= 1'b0;
          o_rdata <= 32'h0;
          o_error <= 1'b0;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_load_store_align.sv
// Bench for cpu_load_store_align: byte-addressed memory model, bus/response scoreboard and
// directed vectors. Honours CPU_MEM_MISALIGNED_EN the same way as the design.
module tb_cpu_load_store_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_request = 1'b0;
  logic        i_rw = 1'b0;
  logic [1:0]  i_width = 2'b00;
  logic        i_signed = 1'b0;
  logic [31:0] i_address = 32'h0;
  logic [31:0] i_wdata = 32'h0;
  logic        o_ready;
  logic [31:0] o_rdata;
  logic        o_error;

  always #5 clk = ~clk;

  cpu_load_store_align_if bus_if ();

  cpu_load_store_align dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_request (i_request),
    .i_rw      (i_rw),
    .i_width   (i_width),
    .i_signed  (i_signed),
    .i_address (i_address),
    .i_wdata   (i_wdata),
    .o_ready   (o_ready),
    .o_rdata   (o_rdata),
    .o_error   (o_error),
    .bus       (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Cache: ready may be combinational; stalls until cycle ready_at.
  int cyc = 0;
  int ready_at = 0;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus_if.bus_ready = bus_if.bus_request && (cyc >= ready_at);

  logic [31:0] cache_mem [logic [31:0]];
  logic [31:0] rdata_drv = 32'h0;
  assign bus_if.bus_rdata = rdata_drv;

  function automatic logic [31:0] cache_rd(input logic [31:0] a);
    return cache_mem.exists(a) ? cache_mem[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (bus_if.bus_request && bus_if.bus_ready && bus_if.bus_rw)
      cache_mem[bus_if.bus_address] = bus_if.bus_wdata;
    #1 rdata_drv = cache_rd(bus_if.bus_address);
  end

  // Reference model: byte-addressed memory and queues of expected traffic.
  logic [7:0] model_mem [logic [31:0]];

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  bus_t  exp_bus[$];
  resp_t exp_resp[$];

  function automatic logic [7:0] model_byte(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = model_byte(a + 32'(i));
    return w;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    cache_mem[a] = w;
    for (int i = 0; i < 4; i++) model_mem[a + 32'(i)] = w[8*i +: 8];
  endtask

  task automatic model(input logic rw, input logic [1:0] width, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    int          size;
    logic        fault;
    logic [31:0] first, lastw, val;
    int          nwords;
    logic        aligned;
    size = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
`ifdef CPU_MEM_MISALIGNED_EN
    fault = (width == 2'b11);
`else
    fault = (width == 2'b11) || ((addr & 32'(size - 1)) != 32'h0);
`endif
    if (fault) begin
      exp_resp.push_back('{rdata: 32'h0, err: 1'b1});
      lat = 1;
      return;
    end
    first  = addr & ~32'h3;
    lastw  = (addr + 32'(size - 1)) & ~32'h3;
    nwords = (lastw != first) ? 2 : 1;
    if (!rw) begin
      for (int w = 0; w < nwords; w++)
        exp_bus.push_back('{rw: 1'b0, addr: first + 32'(4 * w), data: 32'h0});
      val = 32'h0;
      for (int i = 0; i < size; i++) val[8*i +: 8] = model_byte(addr + 32'(i));
      if (size == 1 && sgn && val[7]) val = val | 32'hffff_ff00;
      if (size == 2 && sgn && val[15]) val = val | 32'hffff_0000;
      exp_resp.push_back('{rdata: val, err: 1'b0});
      lat = 1 + nwords;
    end else begin
      aligned = (size == 4) && (addr[1:0] == 2'b00);
      if (!aligned)
        for (int w = 0; w < nwords; w++)
          exp_bus.push_back('{rw: 1'b0, addr: first + 32'(4 * w), data: 32'h0});
      for (int i = 0; i < size; i++) model_mem[addr + 32'(i)] = wdata[8*i +: 8];
      for (int w = 0; w < nwords; w++)
        exp_bus.push_back('{rw: 1'b1, addr: first + 32'(4 * w),
                            data: model_word(first + 32'(4 * w))});
      exp_resp.push_back('{rdata: 32'h0, err: 1'b0});
      lat = aligned ? 2 : 1 + 2 * nwords;
    end
  endtask

  // Compare process: every bus beat, every stalled cycle and every completion.
  logic        prev_stall = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_rw = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] prev_wdata = 32'h0;

  always @(negedge clk) begin
    bus_t  eb;
    resp_t er;
    if (rst_n) begin
      if (bus_if.bus_request) begin
        check("bus_addr_lsbs", {30'h0, bus_if.bus_address[1:0]}, 32'h0);
        if (prev_stall) begin
          check("hold_rw", {31'h0, bus_if.bus_rw}, {31'h0, prev_rw});
          check("hold_addr", bus_if.bus_address, prev_addr);
          check("hold_wdata", bus_if.bus_wdata, prev_wdata);
        end
        if (bus_if.bus_ready) begin
          if (exp_bus.size() == 0) begin
            fail_now("bus_unexpected");
          end else begin
            eb = exp_bus.pop_front();
            check("bus_rw", {31'h0, bus_if.bus_rw}, {31'h0, eb.rw});
            check("bus_addr", bus_if.bus_address, eb.addr);
            if (eb.rw) check("bus_wdata", bus_if.bus_wdata, eb.data);
          end
        end
      end
      if (o_ready) begin
        check("ready_pulse", {31'h0, prev_ready}, 32'h0);
        if (exp_resp.size() == 0) begin
          fail_now("resp_unexpected");
        end else begin
          er = exp_resp.pop_front();
          check("rdata", o_rdata, er.rdata);
          check("error", {31'h0, o_error}, {31'h0, er.err});
        end
      end
      prev_stall = bus_if.bus_request && !bus_if.bus_ready;
      prev_ready = o_ready;
      prev_rw    = bus_if.bus_rw;
      prev_addr  = bus_if.bus_address;
      prev_wdata = bus_if.bus_wdata;
    end else begin
      prev_stall = 1'b0;
      prev_ready = 1'b0;
    end
  end

  task automatic run_cmd(input logic rw, input logic [1:0] width, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                         output logic [31:0] rdata, output logic err);
    int exp_lat;
    int lat;
    model(rw, width, sgn, addr, wdata, exp_lat);
    @(posedge clk);
    #1;
    i_request = 1'b1;
    i_rw      = rw;
    i_width   = width;
    i_signed  = sgn;
    i_address = addr;
    i_wdata   = wdata;
    ready_at  = cyc + 1 + stall;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_ready) begin
        lat = k;
        break;
      end
    end
    rdata = o_rdata;
    err   = o_error;
    i_request = 1'b0;
    if (lat < 0) begin
      fail_now("ready_timeout");
      exp_bus.delete();
      exp_resp.delete();
    end else begin
      if (stall == 0) check("latency", 32'(lat), 32'(exp_lat));
      check("bus_drained", 32'(exp_bus.size()), 32'h0);
    end
    ready_at = 0;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    preload(32'h0000_0200, 32'h1122_3344);
    preload(32'h0000_0300, 32'h80ff_0000);
    preload(32'h0000_0400, 32'haa00_0000);
    preload(32'h0000_0404, 32'h0000_00bb);
    preload(32'hffff_fffc, 32'h0000_0000);
    preload(32'h0000_0000, 32'hffff_ffff);
    preload(32'h0000_0600, 32'h0102_0304);

    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, o_ready}, 32'h0);
    check("rst_rdata", o_rdata, 32'h0);
    check("rst_error", {31'h0, o_error}, 32'h0);
    check("rst_bus_req", {31'h0, bus_if.bus_request}, 32'h0);
    check("rst_bus_addr", bus_if.bus_address, 32'h0);
    check("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
    rst_n = 1'b1;

    run_cmd(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hdead_beef, 0, rd, er);
    check("sw_err", {31'h0, er}, 32'h0);
    check("sw_mem", cache_rd(32'h0000_0100), 32'hdead_beef);

    run_cmd(1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_00ab, 0, rd, er);
    check("sb_mem", cache_rd(32'h0000_0200), 32'h1122_ab44);

    run_cmd(1'b0, 2'b00, 1'b1, 32'h0000_0303, 32'h0, 0, rd, er);
    check("lb_signed", rd, 32'hffff_ff80);
    run_cmd(1'b0, 2'b00, 1'b0, 32'h0000_0303, 32'h0, 0, rd, er);
    check("lbu", rd, 32'h0000_0080);

    run_cmd(1'b0, 2'b01, 1'b0, 32'h0000_0403, 32'h0, 0, rd, er);
`ifdef CPU_MEM_MISALIGNED_EN
    check("lh_cross", rd, 32'h0000_bbaa);
    check("lh_cross_err", {31'h0, er}, 32'h0);
`else
    check("lh_mis_err", {31'h0, er}, 32'h1);
    check("lh_mis_rdata", rd, 32'h0);
`endif

    run_cmd(1'b1, 2'b10, 1'b0, 32'hffff_fffe, 32'h1234_5678, 0, rd, er);
`ifdef CPU_MEM_MISALIGNED_EN
    check("sw_wrap_lo", cache_rd(32'hffff_fffc), 32'h5678_0000);
    check("sw_wrap_hi", cache_rd(32'h0000_0000), 32'hffff_1234);
`else
    check("sw_mis_err", {31'h0, er}, 32'h1);
    check("sw_mis_mem", cache_rd(32'hffff_fffc), 32'h0);
`endif

    run_cmd(1'b1, 2'b01, 1'b0, 32'h0000_0602, 32'h0000_cafe, 3, rd, er);
    check("sh_stall_mem", cache_rd(32'h0000_0600), 32'hcafe_0304);
    run_cmd(1'b0, 2'b01, 1'b1, 32'h0000_0602, 32'h0, 2, rd, er);
    check("lh_signed", rd, 32'hffff_cafe);
    run_cmd(1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0, 0, rd, er);
    check("lw", rd, 32'hcafe_0304);

    run_cmd(1'b0, 2'b11, 1'b0, 32'h0000_0600, 32'h0, 0, rd, er);
    check("reserved_err", {31'h0, er}, 32'h1);

    run_cmd(1'b1, 2'b00, 1'b1, 32'h0000_0203, 32'h1234_56ab, 0, rd, er);
    check("sb_upper_bits", cache_rd(32'h0000_0200), 32'hab22_ab44);

    run_cmd(1'b0, 2'b10, 1'b1, 32'h0000_0601, 32'h0, 1, rd, er);
    run_cmd(1'b1, 2'b01, 1'b0, 32'h0000_0403, 32'h0000_7766, 0, rd, er);

    // Reset while RD0 is stalled: the command is dropped.
    @(posedge clk);
    #1;
    i_request = 1'b1;
    i_rw      = 1'b0;
    i_width   = 2'b10;
    i_address = 32'h0000_0500;
    ready_at  = 1000000;
    @(negedge clk);
    @(negedge clk);
    check("rd0_req", {31'h0, bus_if.bus_request}, 32'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'h0, bus_if.bus_request}, 32'h0);
    check("mid_rst_addr", bus_if.bus_address, 32'h0);
    check("mid_rst_rw", {31'h0, bus_if.bus_rw}, 32'h0);
    check("mid_rst_ready", {31'h0, o_ready}, 32'h0);
    check("mid_rst_rdata", o_rdata, 32'h0);
    i_request = 1'b0;
    ready_at  = 0;
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 0, rd, er);
`ifdef CPU_MEM_MISALIGNED_EN
    check("post_rst_lw", rd, 32'hffff_1234);
`else
    check("post_rst_lw", rd, 32'hffff_ffff);
`endif

    foreach (cache_mem[a]) check("mem_final", cache_mem[a], model_word(a));

    repeat (2) @(negedge clk);
    check("leftover_resp", 32'(exp_resp.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_load_store_align.md
Name: cpu_load_store_align

Overview:
- Load/store alignment stage between the CPU memory stage and the write-buffered data cache.
- Converts byte, halfword and word accesses into aligned 32-bit word transfers. The cache has no byte enables, so sub-word stores become read-modify-write.
- Formats load data: shift, then sign- or zero-extend.
- Optionally splits accesses that cross a word boundary into two word transfers.

Parameters:
- None. The 32-bit datapath is fixed.

Ports:
- i_clock  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  reset. Asynchronous assertion, active-low (0 = reset).
- i_request  in  1  access request; held high and stable until o_ready.
- i_rw  in  1  0 = load, 1 = store.
- i_width  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- i_signed  in  1  load sign-extend enable; ignored for stores.
- i_address  in  32  byte address.
- i_wdata  in  32  store data, right-aligned.
- o_ready  out  1  one-cycle completion pulse.
- o_rdata  out  32  extended load data; valid while o_ready is high.
- o_error  out  1  access fault; valid while o_ready is high.
- o_bus_request  out  1  word request to the data cache.
- o_bus_rw  out  1  0 = read, 1 = write.
- o_bus_address  out  32  word address; bits [1:0] are always 0.
- o_bus_wdata  out  32  write word.
- i_bus_ready  in  1  cache completion; may be combinational from o_bus_request.
- i_bus_rdata  in  32  read word; valid while i_bus_ready is high.

Behaviour:
- Reset values: all outputs 0; state IDLE; capture registers 0.
- Reset mid-operation: any pending bus request drops immediately and the command is lost. A write already accepted by the cache still completes downstream.
- Bus outputs come only from registers; there is no combinational path from i_request to o_bus_*. i_bus_ready is sampled in the same cycle.
- Definitions: off = i_address[1:0]; size = 1, 2 or 4 bytes; cross = (off + size > 4).
- IDLE, when i_request is high: capture rw, width, signed, address and wdata, then:
  - Fault (reserved width, or the fault rule under the optional feature): go to ACK with error = 1; no bus access.
  - Store, word, off = 0: go to WR0.
  - Any other access: go to RD0.
- RD0: read word at address & ~3. On i_bus_ready, latch the data into lo:
  - cross: go to RD1.
  - Load: go to ACK.
  - Store: go to WR0.
- RD1: read word at (address & ~3) + 4, with 32-bit wrap (0xFFFFFFFC → 0x00000000). On ready, latch hi:
  - Load: go to ACK.
  - Store: go to WR0.
- WR0: write lo with the store bytes merged at lanes off .. min(off + size, 4) - 1. On ready:
  - cross: go to WR1.
  - Otherwise: go to ACK.
- WR1: write hi with the remaining store bytes merged at lanes 0 and up. On ready, go to ACK.
- ACK: o_ready = 1 for exactly one cycle, then go to IDLE.
  - Load: o_rdata = ({hi, lo} >> 8·off), truncated to size, then sign- or zero-extended.
  - Store or fault: o_rdata = 0.
  - i_request seen during ACK is ignored; a new command is accepted in the following IDLE cycle.
- While i_bus_ready is low, o_bus_request/rw/address/wdata hold unchanged.
- Minimum latency from request to o_ready, including the capture cycle (IDLE = cycle 0), assuming a zero-wait cache:
  - Aligned word store: 2 cycles.
  - Load: 2 cycles.
  - Sub-word store: 3 cycles.
  - Crossing store: 5 cycles.

Optional Feature:
- Macro: CPU_MEM_MISALIGNED_EN.
- Defined:
  - Crossing accesses take the two-word path (RD1/WR1).
  - o_error is set only for reserved width.
- Undefined:
  - Any misaligned access is a fault: half with off[0] = 1, or word with off ≠ 0.
  - A fault gives ACK with o_error = 1 and no bus traffic.
  - RD1 and WR1 are removed from the state machine.

Test Plan:
- Aligned word store, addr 0x100, data 0xDEADBEEF, zero-wait cache → a single bus write of 0xDEADBEEF to 0x100; o_ready 2 cycles after IDLE capture; o_error = 0.
- Byte store 0xAB to addr 0x201, memory word 0x11223344 → bus read 0x200, then write 0x1122AB44; no other bus traffic.
- Signed byte load from addr 0x303, memory word 0x80FF0000 → o_rdata = 0xFFFFFF80; unsigned variant → 0x00000080.
- Half load from addr 0x403, memory 0x400 = 0xAA000000 and 0x404 = 0x000000BB:
  - With CPU_MEM_MISALIGNED_EN: reads 0x400 then 0x404; o_rdata = 0x0000BBAA.
  - Without it: o_error = 1; no bus request.
- Word store 0x12345678 to addr 0xFFFFFFFE, memory words 0xFFFFFFFC = 0x00000000 and 0x00000000 = 0xFFFFFFFF, with CPU_MEM_MISALIGNED_EN → reads wrap to 0x00000000; writes 0x56780000 to 0xFFFFFFFC and 0xFFFF1234 to 0x00000000.
- Assert i_reset low while in RD0 with i_bus_ready held low → o_bus_request drops in the same cycle; all outputs 0; after release, a word load from 0x0 completes normally.
